// File: rtl/cpu_defs.sv
// cpu_defs: shared CPU definitions for the pipeline control blocks.
// Holds opcode/funct constants, the NOP encoding, the MDU timer state
// encoding and small instruction-decode helpers used by hazard_unit.
package cpu_defs;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } mdu_state_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    // Opcodes whose rt field is a source operand rather than a destination.
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_mdu_op(input logic [31:0] instr);
        return (instr[31:26] == OP_RTYPE) &&
               ((instr[5:0] == FN_MULT) || (instr[5:0] == FN_MULTU) ||
                (instr[5:0] == FN_DIV)  || (instr[5:0] == FN_DIVU));
    endfunction

    function automatic logic is_mdu_reader(input logic [31:0] instr);
        return ((instr[31:26] == OP_RTYPE) &&
                ((instr[5:0] == FN_MFHI) || (instr[5:0] == FN_MFLO))) ||
               is_mdu_op(instr);
    endfunction

endpackage

// File: rtl/mdu_timer.sv
// mdu_timer: tracks an in-flight multiply/divide so that HI/LO readers
// can be held in ID until the result is available.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   ex_mdu_op  - EX currently holds an MDU op
//   hold       - external freeze; blocks the RUN->MDU_WAIT launch only
//   mdu_busy   - MDU result not yet available
// The counter keeps running during hold because the MDU is independent
// of the pipeline freeze.
module mdu_timer
    import cpu_defs::*;
#(
    parameter int unsigned MDU_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_mdu_op,
    input  logic hold,
    output logic mdu_busy
);

    localparam logic [3:0] CNT_LOAD = 4'(MDU_CYCLES - 1);

    mdu_state_t state;
    logic [3:0] mdu_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RUN;
            mdu_cnt <= 4'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    // While held, EX is frozen and the op is seen again later.
                    if (ex_mdu_op && !hold) begin
                        state   <= ST_MDU_WAIT;
                        mdu_cnt <= CNT_LOAD;
                    end
                end
                ST_MDU_WAIT: begin
                    if (ex_mdu_op) begin
                        // Back-to-back MDU op: restart the latency window.
                        mdu_cnt <= CNT_LOAD;
                    end else begin
                        mdu_cnt <= mdu_cnt - 4'd1;
                        if (mdu_cnt == 4'd1)
                            state <= ST_RUN;
                    end
                end
                default: begin
                    state   <= ST_RUN;
                    mdu_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign mdu_busy = ex_mdu_op || (mdu_cnt != 4'd0);

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: front-end pipeline control. Compares ID against EX and
// drives the PC / IF/ID / ID/EX enables and bubble controls.
// Detects load-use hazards, taken-branch flushes and (optionally)
// multiply/divide result hazards.
// Configuration: define HAZARD_MDU_EN to include MDU hazard detection
// (mdu_timer FSM + counter). Without it MDU hazards are never raised.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   ID_INSTR       - instruction in ID
//   EX_INSTR       - instruction in EX
//   BRANCH_TAKEN   - branch in EX resolved taken
//   HOLD           - external freeze request
//   PC_WR, IF_ID_WR, IF_ID_FLUSH, ID_EX_WR, ID_EX_BUBBLE - controls
//   STALL_CYCLES   - saturating count of hazard-stall cycles
module hazard_unit
    import cpu_defs::*;
#(
    parameter int unsigned MDU_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ID_INSTR,
    input  logic [31:0] EX_INSTR,
    input  logic        BRANCH_TAKEN,
    input  logic        HOLD,
    output logic        PC_WR,
    output logic        IF_ID_WR,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_WR,
    output logic        ID_EX_BUBBLE,
    output logic [15:0] STALL_CYCLES
);

    logic [4:0] ex_rt;
    logic       load_use;
    logic       mdu_hazard;
    logic       stall;
    logic       count_stall;

    assign ex_rt = EX_INSTR[20:16];

    assign load_use = is_load(EX_INSTR[31:26]) && (ex_rt != 5'd0) &&
                      ((ex_rt == ID_INSTR[25:21]) ||
                       (reads_rt(ID_INSTR[31:26]) && (ex_rt == ID_INSTR[20:16])));

`ifdef HAZARD_MDU_EN
    logic mdu_busy;

    mdu_timer #(
        .MDU_CYCLES (MDU_CYCLES)
    ) u_mdu_timer (
        .clk       (clk),
        .rst       (rst),
        .ex_mdu_op (is_mdu_op(EX_INSTR)),
        .hold      (HOLD),
        .mdu_busy  (mdu_busy)
    );

    assign mdu_hazard = mdu_busy && is_mdu_reader(ID_INSTR);

    logic unused_bits;
    assign unused_bits = ^{ID_INSTR[15:6], EX_INSTR[15:6]};
`else
    assign mdu_hazard = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{ID_INSTR[15:0], EX_INSTR[15:0], 4'(MDU_CYCLES)};
`endif

    assign stall = load_use || mdu_hazard;

    // Priority: reset > hold > flush > stall > normal.
    always_comb begin
        PC_WR        = 1'b1;
        IF_ID_WR     = 1'b1;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_WR     = 1'b1;
        ID_EX_BUBBLE = 1'b0;
        if (rst || HOLD) begin
            PC_WR    = 1'b0;
            IF_ID_WR = 1'b0;
            ID_EX_WR = 1'b0;
        end else if (BRANCH_TAKEN) begin
            IF_ID_FLUSH  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
        end else if (stall) begin
            PC_WR        = 1'b0;
            IF_ID_WR     = 1'b0;
            ID_EX_BUBBLE = 1'b1;
        end
    end

    assign count_stall = stall && !BRANCH_TAKEN && !HOLD;

    always_ff @(posedge clk) begin
        if (rst)
            STALL_CYCLES <= 16'd0;
        else if (count_stall && (STALL_CYCLES != 16'hFFFF))
            STALL_CYCLES <= STALL_CYCLES + 16'd1;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scoreboard bench for hazard_unit.
// Each step drives ID/EX/branch/hold/reset, pushes the expected control
// word and stall count, and compares them at the following falling edge.
module tb_hazard_unit;

    localparam int unsigned MDU_CYCLES = 4;
`ifdef HAZARD_MDU_EN
    localparam bit MDU_ON = 1'b1;
`else
    localparam bit MDU_ON = 1'b0;
`endif

    // Instruction encodings
    localparam logic [31:0] I_NOP      = 32'h0000_0000;
    localparam logic [31:0] I_LW2      = 32'h8C22_0000; // lw   $2,0($1)
    localparam logic [31:0] I_LW0      = 32'h8C20_0000; // lw   $0,0($1)
    localparam logic [31:0] I_LW5      = 32'h8C25_0000; // lw   $5,0($1)
    localparam logic [31:0] I_LW4      = 32'h8C24_0000; // lw   $4,0($1)
    localparam logic [31:0] I_ADD      = 32'h0044_1820; // add  $3,$2,$4
    localparam logic [31:0] I_SW5      = 32'hACC5_0000; // sw   $5,0($6)
    localparam logic [31:0] I_ADDI5    = 32'h20C5_0001; // addi $5,$6,1
    localparam logic [31:0] I_MULT     = 32'h0022_0018; // mult $1,$2
    localparam logic [31:0] I_MFHI     = 32'h0000_1810; // mfhi $3

    // Control word {PC_WR, IF_ID_WR, IF_ID_FLUSH, ID_EX_WR, ID_EX_BUBBLE}
    localparam logic [4:0] K_NORM  = 5'b11010;
    localparam logic [4:0] K_STALL = 5'b00011;
    localparam logic [4:0] K_FLUSH = 5'b11111;
    localparam logic [4:0] K_OFF   = 5'b00000;

    logic        clk;
    logic        rst;
    logic [31:0] id_instr;
    logic [31:0] ex_instr;
    logic        branch_taken;
    logic        hold;
    logic        pc_wr;
    logic        if_id_wr;
    logic        if_id_flush;
    logic        id_ex_wr;
    logic        id_ex_bubble;
    logic [15:0] stall_cycles;

    hazard_unit #(
        .MDU_CYCLES (MDU_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ID_INSTR     (id_instr),
        .EX_INSTR     (ex_instr),
        .BRANCH_TAKEN (branch_taken),
        .HOLD         (hold),
        .PC_WR        (pc_wr),
        .IF_ID_WR     (if_id_wr),
        .IF_ID_FLUSH  (if_id_flush),
        .ID_EX_WR     (id_ex_wr),
        .ID_EX_BUBBLE (id_ex_bubble),
        .STALL_CYCLES (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [4:0] ctl;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] model_cnt = 16'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, record expectation, compare at falling edge.
    task automatic step(input string tag, input logic r, input logic [31:0] id,
                        input logic [31:0] ex, input logic br, input logic hd,
                        input logic [4:0] kind);
        exp_t e;
        exp_t got;
        @(posedge clk);
        #1;
        rst          = r;
        id_instr     = id;
        ex_instr     = ex;
        branch_taken = br;
        hold         = hd;
        e.tag = tag;
        e.ctl = kind;
        e.cnt = model_cnt;
        exp_q.push_back(e);
        if (r)
            model_cnt = 16'd0;
        else if (kind == K_STALL && model_cnt != 16'hFFFF)
            model_cnt = model_cnt + 16'd1;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            check({got.tag, "_ctl"},
                  {27'd0, pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_bubble},
                  {27'd0, got.ctl});
            check({got.tag, "_cnt"}, {16'd0, stall_cycles}, {16'd0, got.cnt});
        end
    endtask

    initial begin
        logic [4:0] mdu_k;
        rst          = 1'b1;
        id_instr     = I_NOP;
        ex_instr     = I_NOP;
        branch_taken = 1'b0;
        hold         = 1'b0;
        mdu_k        = MDU_ON ? K_STALL : K_NORM;

        // Reset: all controls low even with a hazard present
        step("rst0", 1'b1, I_ADD, I_LW2, 1'b0, 1'b0, K_OFF);
        step("rst1", 1'b1, I_NOP, I_NOP, 1'b1, 1'b0, K_OFF);
        step("idle", 1'b0, I_NOP, I_NOP, 1'b0, 1'b0, K_NORM);

        // Load-use on rs, then bubble in EX
        step("lu_rs",    1'b0, I_ADD, I_LW2, 1'b0, 1'b0, K_STALL);
        step("lu_after", 1'b0, I_ADD, I_NOP, 1'b0, 1'b0, K_NORM);
        step("lu_zero",  1'b0, I_ADD, I_LW0, 1'b0, 1'b0, K_NORM);
        step("lu_rt_add",1'b0, I_ADD, I_LW4, 1'b0, 1'b0, K_STALL);

        // rt-use filter
        step("rt_sw",    1'b0, I_SW5,   I_LW5, 1'b0, 1'b0, K_STALL);
        step("rt_addi",  1'b0, I_ADDI5, I_LW5, 1'b0, 1'b0, K_NORM);

        // Flush overrides stall, no count
        step("flush_lu", 1'b0, I_ADD, I_LW2, 1'b1, 1'b0, K_FLUSH);
        step("flush_nm", 1'b0, I_NOP, I_NOP, 1'b1, 1'b0, K_FLUSH);

        // Hold overrides stall and flush; stall applies after release
        step("hold0",    1'b0, I_ADD, I_LW2, 1'b0, 1'b1, K_OFF);
        step("hold1",    1'b0, I_ADD, I_LW2, 1'b1, 1'b1, K_OFF);
        step("hold2",    1'b0, I_ADD, I_LW2, 1'b0, 1'b1, K_OFF);
        step("hold_rel", 1'b0, I_ADD, I_LW2, 1'b0, 1'b0, K_STALL);
        step("hold_bub", 1'b0, I_ADD, I_NOP, 1'b0, 1'b0, K_NORM);

        // MDU hazard: mult in EX at t, mfhi held t..t+3
        step("mdu_t0", 1'b0, I_MFHI, I_MULT, 1'b0, 1'b0, mdu_k);
        for (int i = 1; i < int'(MDU_CYCLES); i++)
            step($sformatf("mdu_t%0d", i), 1'b0, I_MFHI, I_NOP, 1'b0, 1'b0, mdu_k);
        step("mdu_free", 1'b0, I_MFHI, I_NOP, 1'b0, 1'b0, K_NORM);
        step("mdu_ex",   1'b0, I_NOP, I_MFHI, 1'b0, 1'b0, K_NORM);

        // Reset while waiting on the MDU clears the tracking
        step("mr_t0",  1'b0, I_MFHI, I_MULT, 1'b0, 1'b0, mdu_k);
        step("mr_rst", 1'b1, I_MFHI, I_NOP,  1'b0, 1'b0, K_OFF);
        step("mr_run", 1'b0, I_MFHI, I_NOP,  1'b0, 1'b0, K_NORM);

        // Saturation: long forced stall stream
        @(posedge clk);
        #1;
        id_instr = I_ADD;
        ex_instr = I_LW2;
        for (int i = 0; i < 65540; i++) @(posedge clk);
        model_cnt = 16'hFFFF;
        step("sat0", 1'b0, I_ADD, I_LW2, 1'b0, 1'b0, K_STALL);
        step("sat1", 1'b0, I_ADD, I_LW2, 1'b0, 1'b0, K_STALL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control block that drives the write-enable and bubble inputs of the PC, IF/ID and ID/EX pipeline registers. It compares the instruction in ID against the instruction in EX and detects three cases: load-use hazards, taken-branch flushes, and multiply/divide result hazards. From these it decides each cycle whether the front end advances, stalls, or is squashed. It sits beside the ID stage and is the sole producer of `ID_EX_WR`.

## Interface
Parameters:
- `MDU_CYCLES`, default 4: multiply/divide latency in cycles, counted from the cycle the op occupies EX. Legal range 2..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ID_INSTR`  in  32  instruction currently in ID (IF/ID output).
- `EX_INSTR`  in  32  instruction currently in EX (ID/EX output).
- `BRANCH_TAKEN`  in  1  branch/jump in EX resolved taken this cycle.
- `HOLD`  in  1  external freeze request (memory not ready).
- `PC_WR`  out  1  PC load enable.
- `IF_ID_WR`  out  1  IF/ID load enable.
- `IF_ID_FLUSH`  out  1  IF/ID loads a NOP (32'h0) instead of the fetched instruction.
- `ID_EX_WR`  out  1  ID/EX load enable.
- `ID_EX_BUBBLE`  out  1  ID/EX loads a NOP instead of `ID_INSTR`.
- `STALL_CYCLES`  out  16  saturating count of hazard-stall cycles.

## Operation
- **Load-use.** A load-use hazard exists when all three hold:
  - `EX_INSTR[31:26]` is a load: 0x20, 0x21, 0x23, 0x24 or 0x25.
  - `EX_INSTR[20:16]` is not 0.
  - `EX_INSTR[20:16]` equals either `ID_INSTR[25:21]`, or `ID_INSTR[20:16]` when the ID opcode reads rt (0x00, 0x04, 0x05, 0x28, 0x29, 0x2B).
- **MDU ops.** An MDU op is opcode 0x00 with funct 0x18..0x1B. An MDU reader is opcode 0x00 with funct 0x10 or 0x12, or another MDU op.
- **MDU hazard.** `mdu_busy` = (EX holds an MDU op) OR (`mdu_cnt` != 0). An MDU hazard exists when `mdu_busy` is true and ID holds an MDU reader.
- **Stall** (either hazard):
  - `PC_WR`=0 and `IF_ID_WR`=0.
  - `ID_EX_WR`=1 and `ID_EX_BUBBLE`=1.
  - `STALL_CYCLES` increments, saturating at 16'hFFFF.
- **Flush** (`BRANCH_TAKEN`=1):
  - `PC_WR`=1, `IF_ID_WR`=1, `IF_ID_FLUSH`=1, `ID_EX_BUBBLE`=1.
  - Flush overrides stall.
  - `STALL_CYCLES` is not incremented.
- **Hold** (`HOLD`=1):
  - `PC_WR`, `IF_ID_WR` and `ID_EX_WR` are all 0; `IF_ID_FLUSH` and `ID_EX_BUBBLE` are 0.
  - Hold overrides flush and stall.
  - `mdu_cnt` keeps counting, because the MDU runs independently.
  - A pending flush or stall applies in the first cycle after `HOLD` falls, since EX is unchanged.
- **Normal.** `PC_WR`=`IF_ID_WR`=`ID_EX_WR`=1; `IF_ID_FLUSH`=`ID_EX_BUBBLE`=0.
- **FSM states:**
  - RUN → MDU_WAIT when EX holds an MDU op and `HOLD`=0; `mdu_cnt` loads `MDU_CYCLES`-1.
  - MDU_WAIT decrements `mdu_cnt` each cycle and returns to RUN on the edge where `mdu_cnt` goes 1→0.
  - An MDU op in EX while in MDU_WAIT cannot occur, because readers stall. If it does occur, `mdu_cnt` reloads.
- **Reset and outputs.**
  - While `rst`=1, all five control outputs are 0.
  - Reset values: state=RUN, `mdu_cnt`=0, `STALL_CYCLES`=0.
  - All control outputs are combinational from the inputs, state and `mdu_cnt`.

## Timing
- Hazard decisions take effect in the same cycle they are detected, at zero latency. A load-use stall lasts exactly 1 cycle, because the bubble then sits in EX.
- MDU op in EX at cycle t: a reader in ID is stalled in cycles t..t+`MDU_CYCLES`-1 and enters EX at t+`MDU_CYCLES`+1.
- Asserting `rst` in MDU_WAIT returns the FSM to RUN on the next edge; an in-flight MDU result is not tracked.
- A stall and a flush in the same cycle produce flush behaviour only.

## Configuration
- `HAZARD_MDU_EN` defined:
  - MDU detection, the FSM and `mdu_cnt` are present.
- `HAZARD_MDU_EN` undefined:
  - MDU hazards are never raised and no FSM or counter is instantiated.
  - `MDU_CYCLES` is ignored.
  - Load-use, flush, hold and `STALL_CYCLES` are unchanged.

## Structure
- The shared package `cpu_defs` holds:
  - opcode constants (LW, LB, LBU, LH, LHU, SW, SB, SH, BEQ, BNE, RTYPE);
  - funct constants (MULT, MULTU, DIV, DIVU, MFHI, MFLO);
  - NOP = 32'h0;
  - the FSM state encoding.
- Sub-module `mdu_timer` holds the FSM and `mdu_cnt` and outputs `mdu_busy`. It is instantiated only under `HAZARD_MDU_EN`.

## Test plan
- **Load-use stall.** EX=`lw $2,0($1)`, ID=`add $3,$2,$4` → `PC_WR`=0, `IF_ID_WR`=0, `ID_EX_BUBBLE`=1 for 1 cycle; `STALL_CYCLES`=1. With `$0` as the load target instead → no stall.
- **Rt-use filter.** EX=`lw $5`, ID=`sw $5,0($6)` → stall. EX=`lw $5`, ID=`addi $5,$6,1` → no stall (rt is written, not read).
- **Branch flush.** `BRANCH_TAKEN`=1 together with a load-use hazard → `IF_ID_FLUSH`=1, `ID_EX_BUBBLE`=1, `PC_WR`=1; `STALL_CYCLES` unchanged.
- **MDU hazard.** `MDU_CYCLES`=4, `mult` in EX at t, `mfhi` in ID → stall cycles t..t+3 and `STALL_CYCLES`=4; `mfhi` reaches EX at t+5. Rebuilt without `HAZARD_MDU_EN` → zero stalls.
- **Hold.** `HOLD`=1 for 3 cycles during a load-use hazard → all enables 0 and no count. After release → exactly 1 stall cycle.
- **Reset and saturation.** `rst` asserted in MDU_WAIT → next cycle state=RUN, `mdu_cnt`=0, `STALL_CYCLES`=0. A forced long stall stream saturates `STALL_CYCLES` at 16'hFFFF.
